std_mem_d1_stream_ctrl: RTL

- Sequencer that sits directly upstream of the 1-D memory (`std_mem_d1`: combinational read, one-cycle registered write, `done` pulsed the cycle after `write_en`).
- Fills the memory from a valid/ready input stream, then drains the same words back out on a valid/ready output stream, then pulses `done`.
- Used as a staging buffer: producer writes a block of words, consumer reads the block back.

---
 rtl/std_mem_d1_stream_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/std_mem_d1_stream_ctrl.sv
// Staging-buffer sequencer in front of std_mem_d1: fills a block from an input stream, drains it out.
// Optional build macro STD_MEM_STREAM_REVERSE_EN drains the block in LIFO order instead of FIFO.
module std_mem_d1_stream_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   count,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam logic [IDX_SIZE:0] SIZE_W = SIZE[IDX_SIZE:0];
  localparam logic [IDX_SIZE:0] ONE    = {{IDX_SIZE{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [IDX_SIZE:0]   ptr_q, ptr_d;
  logic [IDX_SIZE:0]   len_q, len_d;
  logic [IDX_SIZE:0]   count_clamped;
  logic [IDX_SIZE:0]   ptr_inc;

  assign count_clamped = (count > SIZE_W) ? SIZE_W : count;
  // ptr carries one extra bit so a full block (len == 2**IDX_SIZE) never wraps to zero.
  assign ptr_inc       = ptr_q + ONE;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    len_d          = len_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    mem_addr0      = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          len_d   = count_clamped;
          ptr_d   = '0;
          state_d = (count_clamped != '0) ? S_FILL : S_FINISH;
        end
      end

      S_FILL: begin
        in_ready       = 1'b1;
        mem_addr0      = ptr_q[IDX_SIZE-1:0];
        mem_write_data = in_data;
        mem_write_en   = in_valid;
        if (in_valid) state_d = S_WAIT;
      end

      S_WAIT: begin
        mem_addr0 = ptr_q[IDX_SIZE-1:0];
        if (mem_done) begin
          if (ptr_inc == len_q) begin
`ifdef STD_MEM_STREAM_REVERSE_EN
            ptr_d = len_q - ONE;
`else
            ptr_d = '0;
`endif
            state_d = S_DRAIN;
          end else begin
            ptr_d   = ptr_inc;
            state_d = S_FILL;
          end
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        mem_addr0 = ptr_q[IDX_SIZE-1:0];
        out_data  = mem_read_data;
        if (out_ready) begin
`ifdef STD_MEM_STREAM_REVERSE_EN
          if (ptr_q == '0) state_d = S_FINISH;
          else             ptr_d   = ptr_q - ONE;
`else
          if (ptr_inc == len_q) state_d = S_FINISH;
          else                  ptr_d   = ptr_inc;
`endif
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        ptr_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

endmodule
